// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: memory_type / memory_rw decode
// values, FSM state codes and the alignment check used by the trap build.
// No ports; imported by lsu_lane_align and load_store_unit.
package load_store_unit_pkg;

    // memory_type encodings (access width / signedness)
    localparam logic [3:0] MT_X  = 4'd0;
    localparam logic [3:0] MT_B  = 4'd1;
    localparam logic [3:0] MT_H  = 4'd2;
    localparam logic [3:0] MT_W  = 4'd3;
    localparam logic [3:0] MT_BU = 4'd4;
    localparam logic [3:0] MT_HU = 4'd5;

    // memory_rw encodings
    localparam logic [1:0] M_X = 2'd0;
    localparam logic [1:0] M_R = 2'd1;
    localparam logic [1:0] M_W = 2'd2;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    // Halves must sit on a 2-byte boundary, words on a 4-byte boundary.
    // Anything that is not a byte or half access is handled as a word.
    function automatic logic is_misaligned(input logic [3:0] mt, input logic [1:0] lo);
        logic mis;
        case (mt)
            MT_B, MT_BU: mis = 1'b0;
            MT_H, MT_HU: mis = lo[0];
            default:     mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Purpose: byte-lane steering for the LSU (strobes, store replication, load extract/extend).
// Latency: purely combinational.
// Backpressure: none; follows whatever type/address the parent presents.
// Ports: memory_type, addr_lo (byte offset in word), store_data, rdata in;
//        wstrb, wdata (lane-replicated store), load_ext (extended load) out.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [3:0]  memory_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // addr_lo[0] is deliberately ignored for halves: with no trap the
        // offending bit is dropped and the enclosing aligned half is used.
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        wstrb    = 4'hF;
        wdata    = store_data;
        load_ext = rdata;
        case (memory_type)
            MT_B, MT_BU: begin
                wstrb    = 4'b0001 << addr_lo;
                wdata    = {4{store_data[7:0]}};
                load_ext = (memory_type == MT_B) ? {{24{byte_sel[7]}}, byte_sel}
                                                 : {24'd0, byte_sel};
            end
            MT_H, MT_HU: begin
                wstrb    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata    = {2{store_data[15:0]}};
                load_ext = (memory_type == MT_H) ? {{16{half_sel[15]}}, half_sel}
                                                 : {16'd0, half_sel};
            end
            default: begin
                // MT_W, and MT_X / unknown codes, move a full word
                wstrb    = 4'hF;
                wdata    = store_data;
                load_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: MEM-stage load/store unit: one word-aligned bus access per instruction.
// Latency: access seen cycle 0, mem_req from cycle 1, results pulse the cycle after mem_ack (min 3 cycles).
// Backpressure: stall held while IDLE-with-access or REQ; mem_req held until mem_ack or timeout.
// Ports: clk, reset (async, active-high); req_valid/memory_type/memory_rw/addr/store_data from decode;
//        stall, load_data, load_valid, bus_err, misaligned to pipeline; mem_* bus with mem_ack/mem_rdata.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned H/W accesses without a bus cycle.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [3:0]        memory_type,
    input  logic [1:0]        memory_rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              bus_err,
    output logic              misaligned,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        mt_q;
    logic [1:0]        lo_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;
    logic [31:0]       load_data_q, load_data_d;
    logic              load_valid_q, load_valid_d;
    logic              bus_err_q, bus_err_d;
    logic              mis_q, mis_d;
    logic              latch_en;

    logic              access;
    logic              mis_now;
    logic              expire;
    logic [3:0]        sel_mt;
    logic [1:0]        sel_lo;
    logic [3:0]        al_wstrb;
    logic [31:0]       al_wdata;
    logic [31:0]       al_load;

    assign access = req_valid && (memory_rw != M_X);
    assign expire = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

`ifdef MISALIGN_TRAP_EN
    assign mis_now = is_misaligned(memory_type, addr[1:0]);
`else
    assign mis_now = 1'b0;
`endif

    // One aligner serves both ends of the access: live decode inputs while
    // IDLE (to build strobes/wdata for the latch), latched type/offset while
    // REQ (to extract the returning read data).
    assign sel_mt = (state_q == LSU_IDLE) ? memory_type : mt_q;
    assign sel_lo = (state_q == LSU_IDLE) ? addr[1:0]   : lo_q;

    lsu_lane_align u_align (
        .memory_type (sel_mt),
        .addr_lo     (sel_lo),
        .store_data  (store_data),
        .rdata       (mem_rdata),
        .wstrb       (al_wstrb),
        .wdata       (al_wdata),
        .load_ext    (al_load)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall        = 1'b0;
        mem_req      = 1'b0;
        latch_en     = 1'b0;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        bus_err_d    = 1'b0;
        mis_d        = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (access) begin
                    stall = 1'b1;
                    if (mis_now) begin
                        state_d     = LSU_DONE;
                        mis_d       = 1'b1;
                        load_data_d = 32'd0;
                    end else begin
                        state_d  = LSU_REQ;
                        latch_en = 1'b1;
                        cnt_d    = '0;
                    end
                end
            end
            LSU_REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                // ack is tested first so a late ack on the expiry cycle still wins
                if (mem_ack) begin
                    state_d      = LSU_DONE;
                    load_valid_d = !we_q;
                    load_data_d  = we_q ? 32'd0 : al_load;
                end else if (expire) begin
                    state_d     = LSU_DONE;
                    bus_err_d   = 1'b1;
                    load_data_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LSU_DONE: begin
                // pipeline advances at the end of this cycle; never relaunch from here
                state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LSU_IDLE;
            cnt_q        <= '0;
            load_data_q  <= 32'd0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            bus_err_q    <= bus_err_d;
            mis_q        <= mis_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mt_q    <= MT_X;
            lo_q    <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wstrb_q <= 4'd0;
            wdata_q <= 32'd0;
        end else if (latch_en) begin
            mt_q    <= memory_type;
            lo_q    <= addr[1:0];
            we_q    <= (memory_rw == M_W);
            addr_q  <= {addr[ADDR_W-1:2], 2'b00};
            wstrb_q <= al_wstrb;
            wdata_q <= al_wdata;
        end
    end

    // Bus fields come straight from the latch so they cannot move during REQ.
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wstrb  = wstrb_q;
    assign mem_wdata  = wdata_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign bus_err    = bus_err_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  memory_type = MT_X;
    logic [1:0]  memory_rw = M_X;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        bus_err;
    logic        misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .memory_type (memory_type),
        .memory_rw   (memory_rw),
        .addr        (addr),
        .store_data  (store_data),
        .stall       (stall),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .bus_err     (bus_err),
        .misaligned  (misaligned),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wstrb   (mem_wstrb),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        lv;
        logic [31:0] ld;
        logic        be;
        logic        mis;
        int          reqc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    function automatic exp_t mk(input string nm, input logic [31:0] a, input logic we,
                                input logic [3:0] strb, input logic [31:0] wd, input logic lv,
                                input logic [31:0] ld, input logic be, input logic mis, input int reqc);
        exp_t e;
        e.name = nm; e.addr = a; e.we = we; e.strb = strb; e.wdata = wd;
        e.lv = lv; e.ld = ld; e.be = be; e.mis = mis; e.reqc = reqc;
        return e;
    endfunction

    // Monitor: observes bus activity and stall, and on each completion
    // (stall falling) pops the oldest expected response and compares.
    int          stall_cnt = 0;
    int          req_cnt = 0;
    bit          unstable = 0;
    bit          prev_stall = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_strb;
    logic        cap_we;

    always @(negedge clk) begin
        if (reset) begin
            stall_cnt = 0; req_cnt = 0; unstable = 0; prev_stall = 0;
        end else begin
            if (stall) stall_cnt++;
            if (mem_req) begin
                if (req_cnt == 0) begin
                    cap_addr = mem_addr; cap_we = mem_we; cap_strb = mem_wstrb; cap_wdata = mem_wdata;
                end else if (mem_addr !== cap_addr || mem_we !== cap_we ||
                             mem_wstrb !== cap_strb || mem_wdata !== cap_wdata) begin
                    unstable = 1;
                end
                req_cnt++;
            end
            if (prev_stall && !stall) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, ".load_valid"}, {31'd0, load_valid}, {31'd0, e.lv});
                    chk({e.name, ".bus_err"}, {31'd0, bus_err}, {31'd0, e.be});
                    chk({e.name, ".misaligned"}, {31'd0, misaligned}, {31'd0, e.mis});
                    chk({e.name, ".req_cycles"}, req_cnt, e.reqc);
                    chk({e.name, ".stall_cycles"}, stall_cnt, e.reqc + 1);
                    if (e.lv || e.be || e.mis)
                        chk({e.name, ".load_data"}, load_data, e.ld);
                    if (e.reqc > 0) begin
                        chk({e.name, ".mem_addr"}, cap_addr, e.addr);
                        chk({e.name, ".mem_we"}, {31'd0, cap_we}, {31'd0, e.we});
                        chk({e.name, ".mem_wstrb"}, {28'd0, cap_strb}, {28'd0, e.strb});
                        chk({e.name, ".bus_stable"}, {31'd0, unstable}, 32'd0);
                        if (e.we) chk({e.name, ".mem_wdata"}, cap_wdata, e.wdata);
                    end
                end
                stall_cnt = 0; req_cnt = 0; unstable = 0;
            end else if (load_valid || bus_err || misaligned) begin
                chk("stray_pulse", {29'd0, load_valid, bus_err, misaligned}, 32'd0);
            end
            prev_stall = stall;
        end
    end

    // Drives one instruction and acts as memory; ack_dly = REQ cycle index
    // carrying mem_ack (-1 = never acknowledge).
    task automatic access(input logic [3:0] mt, input logic [1:0] rw, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd, input int ack_dly,
                          input exp_t e);
        int n;
        bit done;
        n = 0; done = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; memory_type = mt; memory_rw = rw; addr = a; store_data = sd;
        sb.push_back(e);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(posedge clk); #1;
            if (mem_req) begin
                mem_ack   = (n == ack_dly);
                mem_rdata = rd;
                n++;
            end else begin
                mem_ack = 1'b0;
            end
            if (!stall) done = 1;
        end
        mem_ack = 1'b0;
        req_valid = 1'b0;
        chk({e.name, ".completes"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.stall", {31'd0, stall}, 32'd0);
        chk("rst.mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst.pulses", {29'd0, load_valid, bus_err, misaligned}, 32'd0);
        chk("rst.load_data", load_data, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_wstrb_we", {27'd0, mem_we, mem_wstrb}, 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        access(MT_B, M_R, 32'h1003, 32'd0, 32'h80FF_FF00, 0,
               mk("lb", 32'h1000, 0, 4'b1000, 32'd0, 1, 32'hFFFF_FF80, 0, 0, 1));
        access(MT_HU, M_R, 32'h1002, 32'd0, 32'hBEEF_1234, 0,
               mk("lhu", 32'h1000, 0, 4'b1100, 32'd0, 1, 32'h0000_BEEF, 0, 0, 1));
        access(MT_B, M_W, 32'h2001, 32'h1234_56AB, 32'd0, 0,
               mk("sb", 32'h2000, 1, 4'b0010, 32'hABAB_ABAB, 0, 32'd0, 0, 0, 1));
        // ack lands on the same REQ cycle the timeout would fire: ack must win
        access(MT_W, M_R, 32'h4000, 32'd0, 32'hDEAD_BEEF, 3,
               mk("lw_late", 32'h4000, 0, 4'hF, 32'd0, 1, 32'hDEAD_BEEF, 0, 0, 4));
        access(MT_W, M_R, 32'h5000, 32'd0, 32'h5555_5555, -1,
               mk("lw_timeout", 32'h5000, 0, 4'hF, 32'd0, 0, 32'd0, 1, 0, 4));
        access(MT_H, M_R, 32'h1002, 32'd0, 32'h8001_0000, 1,
               mk("lh", 32'h1000, 0, 4'b1100, 32'd0, 1, 32'hFFFF_8001, 0, 0, 2));
        access(MT_H, M_W, 32'h6002, 32'hAAAA_5678, 32'd0, 0,
               mk("sh", 32'h6000, 1, 4'b1100, 32'h5678_5678, 0, 32'd0, 0, 0, 1));
        access(MT_BU, M_R, 32'h1001, 32'd0, 32'h0000_9A00, 0,
               mk("lbu", 32'h1000, 0, 4'b0010, 32'd0, 1, 32'h0000_009A, 0, 0, 1));
        access(MT_X, M_R, 32'h7000, 32'd0, 32'h1122_3344, 0,
               mk("mtx_as_w", 32'h7000, 0, 4'hF, 32'd0, 1, 32'h1122_3344, 0, 0, 1));
        access(MT_W, M_W, 32'h8000, 32'h0102_0304, 32'd0, 2,
               mk("sw", 32'h8000, 1, 4'hF, 32'h0102_0304, 0, 32'd0, 0, 0, 3));
`ifdef MISALIGN_TRAP_EN
        access(MT_W, M_R, 32'h3002, 32'd0, 32'hCAFE_F00D, 0,
               mk("lw_mis", 32'h0, 0, 4'h0, 32'd0, 0, 32'd0, 0, 1, 0));
        access(MT_H, M_R, 32'h1003, 32'd0, 32'h7FFF_0000, 0,
               mk("lh_mis", 32'h0, 0, 4'h0, 32'd0, 0, 32'd0, 0, 1, 0));
`else
        access(MT_W, M_R, 32'h3002, 32'd0, 32'hCAFE_F00D, 0,
               mk("lw_mis", 32'h3000, 0, 4'hF, 32'd0, 1, 32'hCAFE_F00D, 0, 0, 1));
        access(MT_H, M_R, 32'h1003, 32'd0, 32'h7FFF_0000, 0,
               mk("lh_mis", 32'h1000, 0, 4'b1100, 32'd0, 1, 32'h0000_7FFF, 0, 0, 1));
`endif

        // req_valid with M_X is not an access
        @(posedge clk); #1;
        req_valid = 1'b1; memory_type = MT_W; memory_rw = M_X; addr = 32'h9000;
        #1 chk("mx.stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("mx.mem_req", {31'd0, mem_req}, 32'd0);
        req_valid = 1'b0;

        // reset in the middle of REQ abandons the access
        @(posedge clk); #1;
        req_valid = 1'b1; memory_type = MT_W; memory_rw = M_R; addr = 32'hA000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstmid.req_before", {31'd0, mem_req}, 32'd1);
        reset = 1'b1; req_valid = 1'b0;
        #1;
        chk("rstmid.mem_req", {31'd0, mem_req}, 32'd0);
        chk("rstmid.stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // stray ack in IDLE must be ignored
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1 mem_ack = 1'b0;
        chk("idle_ack.outputs", {28'd0, load_valid, bus_err, mem_req, stall}, 32'd0);
        @(posedge clk); #1;
        chk("idle_ack.after", {28'd0, load_valid, bus_err, mem_req, stall}, 32'd0);

        // back to normal after the abandoned access
        access(MT_B, M_R, 32'hB002, 32'd0, 32'h0042_0000, 0,
               mk("lb_after_rst", 32'hB000, 0, 4'b0100, 32'd0, 1, 32'h0000_0042, 0, 0, 1));

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
